// File: rtl/adc_sequencer.sv
// adc_sequencer: scans five ADC channels (settle, start, wait) and publishes one coherent frame per scan
module adc_sequencer #(
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FRAME_INTERVAL = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [11:0] adc_data,
   input  logic        adc_done,
   output logic [2:0]  adc_mux_sel,
   output logic        adc_start,
   output logic [11:0] cell_1_voltage_adc,
   output logic [11:0] cell_2_voltage_adc,
   output logic [11:0] cell_3_voltage_adc,
   output logic [11:0] pack_current_adc,
   output logic [11:0] temperature_adc,
   output logic        frame_valid,
   output logic        adc_timeout,
   output logic [4:0]  timeout_mask,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE, INTERVAL} state_t;
   state_t      state;
   logic [2:0]  ch;
   logic [15:0] cnt;
   logic [11:0] shadow [5];
   logic [11:0] cap [5];
   logic [4:0]  fmask;
   logic [4:0]  mask_nxt;
   logic        hit;
   logic        expire;
   // Shadow/mask values as they will stand after this WAIT cycle; lets the last channel publish on the same edge it completes
   always_comb begin
      hit = state == WAIT && adc_done;
      expire = state == WAIT && !adc_done && cnt == 16'(TIMEOUT_CYCLES - 1);
      for (int i = 0; i < 5; i++) cap[i] = (hit && ch == 3'(i)) ? adc_data : shadow[i];
      mask_nxt = fmask | (expire ? 5'b1 << ch : 5'd0);
   end
   // Sequencer FSM with registered outputs; frame outputs load on the edge entering DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ch <= '0;
         cnt <= '0;
         for (int i = 0; i < 5; i++) shadow[i] <= '0;
         fmask <= '0;
         adc_mux_sel <= '0;
         adc_start <= 1'b0;
         cell_1_voltage_adc <= '0;
         cell_2_voltage_adc <= '0;
         cell_3_voltage_adc <= '0;
         pack_current_adc <= '0;
         temperature_adc <= '0;
         frame_valid <= 1'b0;
         adc_timeout <= 1'b0;
         timeout_mask <= '0;
         busy <= 1'b0;
      end else begin
         adc_start <= 1'b0;
         frame_valid <= 1'b0;
         case (state)
            IDLE: if (enable) begin
               state <= SETTLE;
               ch <= '0;
               cnt <= '0;
               adc_mux_sel <= '0;
               busy <= 1'b1;
            end
            SETTLE: if (cnt == 16'(SETTLE_CYCLES - 1)) begin
               state <= START;
               cnt <= '0;
               adc_start <= 1'b1;
            end else cnt <= cnt + 16'd1;
            START: begin
               state <= WAIT;
               cnt <= '0;
            end
            WAIT: begin
               for (int i = 0; i < 5; i++) shadow[i] <= cap[i];
               fmask <= mask_nxt;
               if (hit || expire) begin
                  cnt <= '0;
                  if (ch == 3'd4) begin
                     state <= DONE;
                     cell_1_voltage_adc <= cap[0];
                     cell_2_voltage_adc <= cap[1];
                     cell_3_voltage_adc <= cap[2];
                     pack_current_adc <= cap[3];
                     temperature_adc <= cap[4];
                     timeout_mask <= mask_nxt;
                     adc_timeout <= |mask_nxt;
                     frame_valid <= 1'b1;
                     fmask <= '0;
                  end else begin
                     state <= SETTLE;
                     ch <= ch + 3'd1;
                     adc_mux_sel <= ch + 3'd1;
                  end
               end else cnt <= cnt + 16'd1;
            end
            DONE: begin
               state <= INTERVAL;
               cnt <= '0;
            end
            INTERVAL: if (cnt == 16'(FRAME_INTERVAL - 1)) begin
               cnt <= '0;
               ch <= '0;
               adc_mux_sel <= '0;
               state <= enable ? SETTLE : IDLE;
               busy <= enable;
            end else cnt <= cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
